// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the calculator ALU front-end: opcodes, datapath widths
// and the sequencer FSM state encoding.
package calc_pkg;

  localparam int OPND_W = 10;
  localparam int RES_W  = 14;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_POW = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_wait_cnt.sv
// Loadable down-counter timing the ALU settle window; done is high during the
// last enabled cycle of the window.
module alu_seq_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = en && (count == CNT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response sequencer driving the calculator ALU; POW runs as repeated MUL.
// Optional statistics counters: define ALU_OP_SEQUENCER_STATS_EN.
module alu_op_sequencer
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_EXP       = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [2:0]        cmd_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [RES_W-1:0]  alu_out,
  output logic              busy
`ifdef ALU_OP_SEQUENCER_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic [15:0]       err_count
`endif
);

  localparam logic [3:0]        SETTLE_V  = 4'(SETTLE_CYCLES);
  localparam logic [OPND_W-1:0] MAX_EXP_V = OPND_W'(MAX_EXP);

  logic [1:0]        state;
  logic [OPND_W-1:0] iter;
  logic              is_pow;
  logic              accept;
  logic              rsp_fire;
  logic              sample;
  logic              pow_more;
  logic              load_wait;
  logic              imm;
  logic              imm_err;
  logic [RES_W-1:0]  imm_res;

  assign accept    = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign busy      = (state != ST_IDLE);
  assign pow_more  = is_pow && (iter != OPND_W'(1)) && (alu_out <= RES_W'(1023));
  assign load_wait = (accept && !imm) || (sample && pow_more);

  // Commands answered without touching the ALU
  always_comb begin
    imm     = 1'b0;
    imm_err = 1'b0;
    imm_res = '0;
    case (cmd_op)
      OP_ADD, OP_SUB, OP_MUL: ;
      OP_DIV: begin
        if (cmd_b == '0) begin
          imm     = 1'b1;
          imm_err = 1'b1;
        end
      end
      OP_POW: begin
        if (cmd_b > MAX_EXP_V) begin
          imm     = 1'b1;
          imm_err = 1'b1;
        end else if (cmd_b == '0) begin
          imm     = 1'b1;
          imm_res = RES_W'(1);
        end else if (cmd_b == OPND_W'(1)) begin
          imm     = 1'b1;
          imm_res = RES_W'(cmd_a);
        end
      end
      default: begin
        imm     = 1'b1;
        imm_err = 1'b1;
      end
    endcase
  end

  alu_seq_wait_cnt #(.CNT_W(4)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_wait),
    .load_val (SETTLE_V),
    .en       (state == ST_WAIT),
    .done     (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      iter       <= '0;
      is_pow     <= 1'b0;
    end else begin
      cmd_ready <= ((state == ST_IDLE) && !accept) || ((state == ST_DONE) && rsp_fire);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (imm) begin
              state      <= ST_DONE;
              rsp_valid  <= 1'b1;
              rsp_result <= imm_res;
              rsp_err    <= imm_err;
            end else begin
              state  <= ST_WAIT;
              alu_a  <= cmd_a;
              alu_b  <= (cmd_op == OP_POW) ? cmd_a : cmd_b;
              alu_op <= (cmd_op == OP_POW) ? OP_MUL : cmd_op;
              is_pow <= (cmd_op == OP_POW);
              iter   <= cmd_b - 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (sample) begin
            if (is_pow) begin
              iter <= iter - 1'b1;
              if (iter == OPND_W'(1)) begin
                state      <= ST_DONE;
                rsp_valid  <= 1'b1;
                rsp_result <= alu_out;
                rsp_err    <= 1'b0;
              end else if (alu_out > RES_W'(1023)) begin
                state      <= ST_DONE;
                rsp_valid  <= 1'b1;
                rsp_result <= '0;
                rsp_err    <= 1'b1;
              end else begin
                alu_a <= alu_out[OPND_W-1:0];
              end
            end else begin
              state      <= ST_DONE;
              rsp_valid  <= 1'b1;
              rsp_result <= alu_out;
              rsp_err    <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (rsp_fire) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_OP_SEQUENCER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (rsp_fire) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 1'b1;
      if (rsp_err && (err_count != 16'hFFFF)) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3) share stimulus and
// are checked against a behavioural ALU and command model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [9:0]  cmd_a;
  logic [9:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_ready;

  logic        cmd_ready1, rsp_valid1, rsp_err1, busy1;
  logic [13:0] rsp_result1, alu_out1;
  logic [9:0]  alu_a1, alu_b1;
  logic [2:0]  alu_op1;
  logic        cmd_ready3, rsp_valid3, rsp_err3, busy3;
  logic [13:0] rsp_result3, alu_out3;
  logic [9:0]  alu_a3, alu_b3;
  logic [2:0]  alu_op3;
`ifdef ALU_OP_SEQUENCER_STATS_EN
  logic [15:0] op_count1, err_count1, op_count3, err_count3;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int exp_ops    = 0;
  int exp_errs   = 0;

  always #5 clk = ~clk;

  function automatic logic [13:0] alu_fn(input logic [9:0] a, input logic [9:0] b,
                                         input logic [2:0] op);
    int r;
    case (op)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = int'(a) - int'(b);
      3'd2:    r = int'(a) * int'(b);
      3'd3:    r = (b == 10'd0) ? 0 : int'(a) / int'(b);
      default: r = 0;
    endcase
    return 14'(r);
  endfunction

  assign alu_out1 = alu_fn(alu_a1, alu_b1, alu_op1);
  assign alu_out3 = alu_fn(alu_a3, alu_b3, alu_op3);

  alu_op_sequencer #(.SETTLE_CYCLES(1), .MAX_EXP(15)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result1), .rsp_err(rsp_err1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_out(alu_out1),
    .busy(busy1)
`ifdef ALU_OP_SEQUENCER_STATS_EN
    , .op_count(op_count1), .err_count(err_count1)
`endif
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3), .MAX_EXP(15)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result3), .rsp_err(rsp_err3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_out(alu_out3),
    .busy(busy3)
`ifdef ALU_OP_SEQUENCER_STATS_EN
    , .op_count(op_count3), .err_count(err_count3)
`endif
  );

  // Expected response from the command rules; lat = cycles from accept to rsp_valid
  task automatic model(input int a, input int b, input int op, input int s,
                       output int err, output int res, output int lat);
    int p, issues;
    err = 0; res = 0; lat = 1;
    if (op > 4 || (op == 3 && b == 0)) begin
      err = 1;
    end else if (op == 4) begin
      if (b > 15) err = 1;
      else if (b == 0) res = 1;
      else if (b == 1) res = a;
      else begin
        p = a; issues = 0;
        for (int k = 1; k < b; k++) begin
          p = (p * a) % 16384;
          issues++;
          if (k == b - 1) res = p;
          else if (p > 1023) begin
            err = 1;
            break;
          end
        end
        lat = issues * s + 1;
      end
    end else begin
      res = int'(alu_fn(10'(a), 10'(b), 3'(op)));
      lat = s + 1;
    end
  endtask

  task automatic do_cmd(input int a, input int b, input int op, input int hold,
                        input string tag);
    int e, r, l1, l3, dummy_e, dummy_r, lat1, lat3, pa;
    model(a, b, op, 1, e, r, l1);
    model(a, b, op, 3, dummy_e, dummy_r, l3);
    @(negedge clk);
    for (int k = 0; k < 50 && !(cmd_ready1 && cmd_ready3); k++) @(negedge clk);
    vectors++;
    if (!(cmd_ready1 && cmd_ready3)) begin
      miscompares++;
      $display("FAIL %s cmd_ready: got %b/%b expected 1/1", tag, cmd_ready1, cmd_ready3);
    end
    cmd_a = 10'(a); cmd_b = 10'(b); cmd_op = 3'(op); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = 10'($urandom); cmd_b = 10'($urandom);
    lat1 = 0; lat3 = 0; pa = a;
    for (int c = 1; c <= 300; c++) begin
      if (rsp_valid1 && lat1 == 0) lat1 = c;
      if (rsp_valid3 && lat3 == 0) lat3 = c;
      if (lat1 == 0) begin
        vectors++;
        if (op == 4) begin
          if ({alu_a1, alu_b1, alu_op1} !== {10'(pa), 10'(a), 3'd2}) begin
            miscompares++;
            $display("FAIL %s alu_inputs c=%0d: got a=%0d b=%0d op=%0d expected a=%0d b=%0d op=2",
                     tag, c, alu_a1, alu_b1, alu_op1, pa % 1024, a);
          end
          pa = (pa * a) % 16384;
        end else if ({alu_a1, alu_b1, alu_op1} !== {10'(a), 10'(b), 3'(op)}) begin
          miscompares++;
          $display("FAIL %s alu_inputs: got a=%0d b=%0d op=%0d expected a=%0d b=%0d op=%0d",
                   tag, alu_a1, alu_b1, alu_op1, a, b, op);
        end
      end
      if (lat1 != 0 && lat3 != 0) break;
      @(negedge clk);
    end
    vectors++;
    if (lat1 != l1 || lat3 != l3) begin
      miscompares++;
      $display("FAIL %s latency: got %0d/%0d expected %0d/%0d", tag, lat1, lat3, l1, l3);
    end
    vectors++;
    if ({rsp_result1, rsp_err1} !== {14'(r), 1'(e)} || {rsp_result3, rsp_err3} !== {14'(r), 1'(e)}) begin
      miscompares++;
      $display("FAIL %s result: got %0d/%0d err %b/%b expected %0d err %0d",
               tag, rsp_result1, rsp_result3, rsp_err1, rsp_err3, r, e);
    end
    // Backpressure: response must hold while a competing command is offered
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_a = 10'($urandom); cmd_b = 10'($urandom);
      @(negedge clk);
      vectors++;
      if ({rsp_valid1, rsp_valid3, cmd_ready1, cmd_ready3, rsp_result1, rsp_err1} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 14'(r), 1'(e)}) begin
        miscompares++;
        $display("FAIL %s hold h=%0d: got valid=%b ready=%b result=%0d err=%b expected valid=1 ready=0 result=%0d err=%0d",
                 tag, h, rsp_valid1, cmd_ready1, rsp_result1, rsp_err1, r, e);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    exp_ops++;
    if (e != 0) exp_errs++;
    vectors++;
    if ({rsp_valid1, rsp_valid3, busy1, busy3, cmd_ready1, cmd_ready3} !== 6'b000011) begin
      miscompares++;
      $display("FAIL %s after_handshake: got valid=%b%b busy=%b%b ready=%b%b expected valid=00 busy=00 ready=11",
               tag, rsp_valid1, rsp_valid3, busy1, busy3, cmd_ready1, cmd_ready3);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({cmd_ready1, rsp_valid1, rsp_result1, rsp_err1, alu_a1, alu_b1, alu_op1, busy1,
         cmd_ready3, rsp_valid3, rsp_result3, rsp_err3, alu_a3, alu_b3, alu_op3, busy3} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: got ready=%b valid=%b result=%0d alu_a=%0d busy=%b expected all 0",
               tag, cmd_ready1, rsp_valid1, rsp_result1, alu_a1, busy1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready1, cmd_ready3, busy1, rsp_valid1} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b%b busy=%b valid=%b expected ready=11 busy=0 valid=0",
               cmd_ready1, cmd_ready3, busy1, rsp_valid1);
    end
  endtask

  task automatic test_add();
    do_cmd(1, 17, 0, 0, "add");
    do_cmd(500, 700, 1, 0, "sub_underflow");
    do_cmd(1000, 7, 3, 0, "div");
  endtask

  task automatic test_pow();
    do_cmd(9, 3, 4, 0, "pow_9_3");
    do_cmd(2, 13, 4, 0, "pow_2_13");
  endtask

  task automatic test_boundary_errors();
    do_cmd(5, 0, 3, 0, "div_zero");
    do_cmd(12, 34, 6, 0, "illegal_op");
    do_cmd(2, 16, 4, 0, "pow_exp_16");
    do_cmd(1, 15, 4, 0, "pow_exp_15");
  endtask

  task automatic test_pow_edges();
    do_cmd(40, 3, 4, 0, "pow_overflow");
    do_cmd(7, 0, 4, 0, "pow_b0");
    do_cmd(7, 1, 4, 0, "pow_b1");
  endtask

  task automatic test_backpressure();
    do_cmd(79, 98, 2, 5, "mul_backpressure");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_cmd(i * 100 + 3, i + 2, i, 1, "back_to_back");
  endtask

  task automatic test_random();
    int op, a, b;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      a = $urandom_range(0, 1023);
      b = $urandom_range(0, 1023);
      if (op == 4) begin
        a = $urandom_range(0, 12);
        b = $urandom_range(0, 17);
      end else if (op == 3 && $urandom_range(0, 3) == 0) begin
        b = 0;
      end
      do_cmd(a, b, op, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    cmd_a = 10'd3; cmd_b = 10'd6; cmd_op = 3'd4; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy1, busy3, rsp_valid1} !== 3'b110) begin
      miscompares++;
      $display("FAIL abort_in_wait: got busy=%b%b valid=%b expected busy=11 valid=0",
               busy1, busy3, rsp_valid1);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort_reset");
    exp_ops = 0; exp_errs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid1, rsp_valid3, busy1, cmd_ready1} !== 4'b0001) begin
        miscompares++;
        $display("FAIL abort_after_release i=%0d: got valid=%b%b busy=%b ready=%b expected valid=00 busy=0 ready=1",
                 i, rsp_valid1, rsp_valid3, busy1, cmd_ready1);
      end
    end
    rsp_ready = 1'b0;
  endtask

`ifdef ALU_OP_SEQUENCER_STATS_EN
  task automatic test_stats();
    do_cmd(3, 4, 0, 0, "stats_add");
    do_cmd(5, 0, 3, 0, "stats_div0");
    do_cmd(3, 4, 4, 0, "stats_pow");
    do_cmd(1, 1, 7, 0, "stats_illegal");
    do_cmd(6, 7, 2, 2, "stats_mul");
    vectors++;
    if ({op_count1, err_count1, op_count3, err_count3} !==
        {16'(exp_ops), 16'(exp_errs), 16'(exp_ops), 16'(exp_errs)}) begin
      miscompares++;
      $display("FAIL stats: got op=%0d err=%0d expected op=%0d err=%0d",
               op_count1, err_count1, exp_ops, exp_errs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_pow();
    test_boundary_errors();
    test_pow_edges();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_abort();
`ifdef ALU_OP_SEQUENCER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
